// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions.
package cp0_pkg;

    // CP0 register numbers as seen by mfc0/mtc0
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // SR field positions
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int SR_IM_LO = 10;
    localparam int SR_IM_HI = 15;

    // Cause field positions
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    // Exception vector used by the fetch stage
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

    // Pack the architectural SR fields into the 32-bit register image
    function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl, input logic ie);
        logic [31:0] w;
        w = '0;
        w[SR_IM_HI:SR_IM_LO] = im;
        w[SR_EXL]            = exl;
        w[SR_IE]             = ie;
        return w;
    endfunction

    // Pack the architectural Cause fields into the 32-bit register image
    function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip, input logic [4:0] code);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD]                    = bd;
        w[CAUSE_IP_HI:CAUSE_IP_LO]     = ip;
        w[CAUSE_EXC_HI:CAUSE_EXC_LO]   = code;
        return w;
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0 in the M stage: SR/Cause/EPC/PRId, mfc0/mtc0/eret and
// interrupt-vs-exception arbitration driving the M/W flush.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID       = 32'h0000_1234,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        exc_valid_m,
    input  logic [4:0]  exc_code_m,
    input  logic [5:0]  hw_int,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic        eret_m,
    output logic [31:0] rdata,
    output logic [31:0] epc_out,
    output logic        int_req
);

    // Architectural state
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic irq, exc;

    // HANDLER_PC is consumed by the fetch stage; wdata[1:0] never lands anywhere
    logic [31:0] unused_handler_pc;
    logic [1:0]  unused_wdata_lo;
    assign unused_handler_pc = HANDLER_PC;
    assign unused_wdata_lo   = wdata[1:0];

    // Live hw_int is used so an interrupt is taken the cycle it appears.
    // While reset is held the request is forced low regardless of M inputs.
    assign irq     = (|(hw_int & im_q)) & ie_q & ~exl_q;
    assign exc     = exc_valid_m & ~exl_q;
    assign int_req = reset & (irq | exc);

    // EPC with same-cycle mtc0 bypass for an eret that follows immediately
    assign epc_out = (reset && we && addr == CP0_EPC && !int_req) ? {wdata[31:2], 2'b00} : epc_q;

    // mfc0 read mux
    always_comb begin
        rdata = '0;
        case (addr)
            CP0_SR:    rdata = sr_word(im_q, exl_q, ie_q);
            CP0_CAUSE: rdata = cause_word(bd_q, ip_q, exccode_q);
            CP0_EPC:   rdata = epc_q;
            CP0_PRID:  rdata = PRID;
            default:   rdata = '0;
        endcase
    end

    // Next state: exception entry beats mtc0, eret clears EXL when not flushing
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (int_req) begin
            exl_d     = 1'b1;
            exccode_d = irq ? EXC_INT : exc_code_m;
            bd_d      = bd_m;
            epc_d     = bd_m ? (pc_m - 32'd4) : pc_m;
        end else begin
            if (we) begin
                case (addr)
                    CP0_SR: begin
                        im_d  = wdata[SR_IM_HI:SR_IM_LO];
                        exl_d = wdata[SR_EXL];
                        ie_d  = wdata[SR_IE];
                    end
                    CP0_EPC: epc_d = {wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
            if (eret_m) exl_d = 1'b0;
        end
    end

    // State registers; IP tracks hw_int every cycle with one cycle of latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= hw_int;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: word-level reference model checked every
// cycle, plus hand-computed expectations at key points of the sequence.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_m;
    logic        bd_m;
    logic        exc_valid_m;
    logic [4:0]  exc_code_m;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret_m;
    logic [31:0] rdata;
    logic [31:0] epc_out;
    logic        int_req;

    int n_cmp = 0;
    int n_err = 0;

    cp0_unit dut (
        .clk(clk), .reset(reset), .pc_m(pc_m), .bd_m(bd_m),
        .exc_valid_m(exc_valid_m), .exc_code_m(exc_code_m), .hw_int(hw_int),
        .we(we), .addr(addr), .wdata(wdata), .eret_m(eret_m),
        .rdata(rdata), .epc_out(epc_out), .int_req(int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whole 32-bit register images
    logic [31:0] m_sr, m_cause, m_epc;

    function automatic logic m_irq();
        return (|(hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_take();
        return reset && (m_irq() || (exc_valid_m && !m_sr[1]));
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_1234;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [31:0] sr, cause, epc;
        if (!reset) begin
            m_sr    <= 32'h0;
            m_cause <= 32'h0;
            m_epc   <= 32'h0;
        end else begin
            sr = m_sr; cause = m_cause; epc = m_epc;
            if (m_take()) begin
                sr[1]      = 1'b1;
                cause[6:2] = m_irq() ? 5'd0 : exc_code_m;
                cause[31]  = bd_m;
                epc        = bd_m ? pc_m - 32'd4 : pc_m;
            end else begin
                if (we && addr == 5'd12) sr = wdata & 32'h0000_FC03;
                if (we && addr == 5'd14) epc = wdata & 32'hFFFF_FFFC;
                if (eret_m) sr[1] = 1'b0;
            end
            cause[15:10] = hw_int;
            m_sr    <= sr;
            m_cause <= cause;
            m_epc   <= epc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the rising edge
    always @(negedge clk) begin
        logic [31:0] e_epc;
        e_epc = (reset && we && addr == 5'd14 && !m_take()) ? (wdata & 32'hFFFF_FFFC) : m_epc;
        chk("model.int_req", {31'b0, int_req}, {31'b0, m_take()});
        chk("model.rdata", rdata, m_rdata(addr));
        chk("model.epc_out", epc_out, e_epc);
    end

    task automatic step();
        @(posedge clk);
        #1;
        we = 0; eret_m = 0; exc_valid_m = 0;
    endtask

    initial begin
        reset = 0; pc_m = 0; bd_m = 0; exc_valid_m = 0; exc_code_m = 0;
        hw_int = 0; we = 0; addr = 5'd15; wdata = 0; eret_m = 0;
        #2;
        chk("reset.prid", rdata, 32'h0000_1234);
        chk("reset.int_req", {31'b0, int_req}, 32'h0);
        chk("reset.epc_out", epc_out, 32'h0);

        // mtc0 EPC with same-cycle bypass
        step(); reset = 1; we = 1; addr = 5'd14; wdata = 32'h3010; #2;
        chk("bypass.3010", epc_out, 32'h3010);
        step(); addr = 5'd14; #2;
        chk("epc.3010", rdata, 32'h3010);

        // asynchronous reset mid-run
        step(); reset = 0; addr = 5'd15; #2;
        chk("areset.epc_out", epc_out, 32'h0);
        chk("areset.prid", rdata, 32'h0000_1234);
        chk("areset.int_req", {31'b0, int_req}, 32'h0);

        // enable IM0 + IE, then a timer interrupt
        step(); reset = 1; we = 1; addr = 5'd12; wdata = 32'h0000_0401; #2;
        step(); hw_int = 6'b000001; pc_m = 32'h3020; bd_m = 0; #2;
        chk("irq.int_req", {31'b0, int_req}, 32'h1);
        step(); addr = 5'd13; #2;
        chk("irq.cause", rdata, 32'h0000_0400);
        chk("irq.epc", epc_out, 32'h3020);
        chk("irq.int_req_masked", {31'b0, int_req}, 32'h0);

        // EXL masks both exception and interrupt
        step(); addr = 5'd12; exc_valid_m = 1; exc_code_m = 5'd12; pc_m = 32'h3050; #2;
        chk("exl.sr", rdata, 32'h0000_0403);
        chk("exl.int_req", {31'b0, int_req}, 32'h0);
        step(); eret_m = 1; #2;
        chk("eret.int_req", {31'b0, int_req}, 32'h0);
        step(); pc_m = 32'h3060; #2;
        chk("pending.int_req", {31'b0, int_req}, 32'h1);
        step(); hw_int = 0; addr = 5'd14; eret_m = 1; #2;
        chk("pending.epc", rdata, 32'h3060);

        // synchronous exception in a delay slot with IE=0
        step(); we = 1; addr = 5'd12; wdata = 32'h0; #2;
        step(); exc_valid_m = 1; exc_code_m = 5'd12; pc_m = 32'h3040; bd_m = 1; #2;
        chk("exc.int_req", {31'b0, int_req}, 32'h1);
        step(); bd_m = 0; addr = 5'd13; #2;
        chk("exc.cause", rdata, 32'h8000_0030);
        chk("exc.epc", epc_out, 32'h303C);
        step(); eret_m = 1; addr = 5'd12; #2;
        chk("exc.sr", rdata, 32'h0000_0002);

        // mtc0 EPC bypass, then dropped under an interrupt
        step(); we = 1; addr = 5'd14; wdata = 32'h3103; #2;
        chk("bypass.3100", epc_out, 32'h3100);
        step(); addr = 5'd14; #2;
        chk("epc.3100", rdata, 32'h3100);
        step(); we = 1; addr = 5'd12; wdata = 32'h0000_0401; #2;
        step(); hw_int = 6'b000001; we = 1; addr = 5'd14; wdata = 32'h3203; pc_m = 32'h3080; #2;
        chk("drop.int_req", {31'b0, int_req}, 32'h1);
        chk("drop.epc_out", epc_out, 32'h3100);
        step(); hw_int = 0; addr = 5'd14; eret_m = 1; #2;
        chk("drop.epc", rdata, 32'h3080);

        // interrupt and exception together: interrupt wins
        step(); hw_int = 6'b000001; exc_valid_m = 1; exc_code_m = 5'd4; pc_m = 32'h30A0; #2;
        chk("both.int_req", {31'b0, int_req}, 32'h1);
        step(); hw_int = 0; addr = 5'd13; #2;
        chk("both.cause", rdata, 32'h0000_0400);
        step(); eret_m = 1; #2;

        // reset during a live interrupt line; IE=0 afterwards
        step(); reset = 0; hw_int = 6'b000001; #2;
        chk("rst_irq.int_req", {31'b0, int_req}, 32'h0);
        step(); reset = 1; #2;
        chk("post_rst.int_req", {31'b0, int_req}, 32'h0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 for the 5-stage MIPS pipeline, located in the M stage beside data memory. Holds SR, Cause, EPC and PRId, services mfc0/mtc0/eret issued from M, and arbitrates hardware interrupts against M-stage exceptions. Its read data feeds the M/W pipeline register's cp0 input. Its `int_req` output is that register's `IntReg` flush input, also used upstream to redirect the PC to the handler.

## Interface
Parameters:
- PRID, 32'h0000_1234, read-only processor ID returned at address 15
- HANDLER_PC, 32'h0000_4180, exception vector (exported as a constant; not used internally)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- pc_m  in  32  PC of the instruction currently in M (bubble PC as carried by the pipeline)
- bd_m  in  1  M instruction sits in a branch delay slot
- exc_valid_m  in  1  M instruction raised a synchronous exception
- exc_code_m  in  5  ExcCode of that exception (4 AdEL, 5 AdES, 10 RI, 12 Ov)
- hw_int  in  6  level-sensitive hardware interrupt lines (timer0, timer1, device, …)
- we  in  1  mtc0 in M
- addr  in  5  CP0 register number for mtc0/mfc0
- wdata  in  32  mtc0 source data
- eret_m  in  1  eret in M
- rdata  out  32  mfc0 read data (combinational on addr)
- epc_out  out  32  EPC for eret redirect (with same-cycle mtc0 bypass)
- int_req  out  1  take exception/interrupt this cycle; flushes M/W and earlier stages

## Operation
- SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0. mtc0 writes only these fields.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]; not writable by mtc0. IP is sampled from hw_int every cycle.
- EPC (14): full 32 bits writable by mtc0; bits [1:0] forced to 0 on every write.
- PRId (15): constant PRID. Any other addr reads 0.
- irq = |(hw_int & SR.IM) & SR.IE & ~SR.EXL (uses live hw_int, not registered IP).
- exc = exc_valid_m & ~SR.EXL.
- int_req = irq | exc. Interrupt has priority over exception.
- On int_req at the clock edge:
  - EXL ← 1
  - ExcCode ← 0 if irq, else exc_code_m
  - BD ← bd_m
  - EPC ← bd_m ? pc_m − 4 : pc_m
  - mtc0 in the same cycle is suppressed.
- On eret_m & ~int_req: EXL ← 0. int_req is normally masked because EXL=1 during a handler.
- With EXL=1, exceptions and interrupts are ignored and Cause is not updated; only IP keeps tracking.
- epc_out = (we & addr==14 & ~int_req) ? {wdata[31:2],2'b00} : EPC.

## Timing
- Reset (asynchronous, while reset=0): SR, Cause, EPC = 0; rdata = 0 unless addr=15; epc_out = 0; int_req = 0.
- int_req is combinational (same cycle as the M inputs); all state updates occur on the following rising edge, coincident with the M/W flush.
- rdata is combinational; a mfc0 immediately after an mtc0 to the same register reads the new value, because the write commits at the edge between them.
- IP reflects hw_int with one cycle of latency.
- A reset deassertion mid-interrupt discards the pending request; hw_int still high after reset does not fire because IE=0.

## Structure
- Shared package cp0_pkg: register numbers (SR=12, CAUSE=13, EPC=14, PRID=15), ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12), SR/Cause field bit positions, and the HANDLER_PC value.
- Single module. The irq/exc arbitration is small enough to stay inline, so no sub-module is needed.

## Test plan
- Reset low mid-run with EPC=0x3010 → EPC=0, SR=0, int_req=0 immediately; addr=15 reads 0x00001234.
- mtc0 SR ← 0x0000_0401, hw_int=6'b000001, pc_m=0x3020, bd_m=0 → int_req=1; next cycle EPC=0x3020, EXL=1, ExcCode=0, rdata(13)[10]=1.
- exc_valid_m=1, code 12, pc_m=0x3040, bd_m=1, IE=0 → int_req=1; EPC=0x303C, BD=1, ExcCode=12.
- EXL=1 with hw_int asserted and exc_valid_m=1 → int_req=0, EPC unchanged; then eret_m → EXL=0 and the pending interrupt fires the next cycle.
- Same-cycle mtc0 EPC ← 0x3103 → epc_out=0x3100 that cycle; the same mtc0 with irq active → write dropped, EPC ← pc_m.
- irq and exc_valid_m together → ExcCode=0 (interrupt wins).
